mem_rd_arb_mux: RTL and testbench

MEM_RD_ARB_MUX -- requirements
Module: mem_rd_arb_mux

---
 rtl/mem_rd_arb_mux.sv | 135 +++++++++++++
 tb/tb_mem_rd_arb_mux.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_arb_mux.sv
// Read-request arbiter/mux: N requesters share one downstream read port.
// A tag FIFO of source indices routes in-order responses back to their owners.
module mem_rd_arb_mux #(
    parameter int NUM_SRCS  = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4,
    parameter int ARB_RR    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRCS-1:0]          src_rd_req_val,
    input  logic [NUM_SRCS*ADDR_W-1:0]   src_rd_req_addr,
    output logic [NUM_SRCS-1:0]          src_rd_req_rdy,
    output logic [NUM_SRCS-1:0]          src_rd_resp_val,
    output logic [DATA_W-1:0]            src_rd_resp_data,
    input  logic [NUM_SRCS-1:0]          src_rd_resp_rdy,
    output logic                         dst_rd_req_val,
    output logic [ADDR_W-1:0]            dst_rd_req_addr,
    input  logic                         dst_rd_req_rdy,
    input  logic                         dst_rd_resp_val,
    input  logic [DATA_W-1:0]            dst_rd_resp_data,
    output logic                         dst_rd_resp_rdy,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt
);

    localparam int SRC_W = $clog2(NUM_SRCS);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [SRC_W-1:0] tag_mem [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full_q;
    logic             empty_q;
    logic [SRC_W-1:0] last_grant;

    logic [SRC_W-1:0] arb_base;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] head;
    logic             full;
    logic             empty;
    logic             req_hs;
    logic             resp_hs;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // While rst is high the block presents itself as freshly reset (empty FIFO, source 0 first).
    assign full     = full_q & ~rst;
    assign empty    = empty_q | rst;
    assign arb_base = rst ? SRC_W'(NUM_SRCS - 1) : last_grant;

    // Descending loops let the highest-priority candidate be the last (winning) assignment.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        grant = '0;
        if (ARB_RR != 0) begin
            for (int off = NUM_SRCS; off >= 1; off--) begin
                int idx;
                idx = (int'(arb_base) + off) % NUM_SRCS;
                if (src_rd_req_val[SRC_W'(idx)]) grant = SRC_W'(idx);
            end
        end else begin
            for (int i = NUM_SRCS - 1; i >= 0; i--) begin
                if (src_rd_req_val[i]) grant = SRC_W'(i);
            end
        end
    end

    always_comb begin
        dst_rd_req_addr = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            if (grant == SRC_W'(i)) dst_rd_req_addr = src_rd_req_addr[i*ADDR_W +: ADDR_W];
        end
        dst_rd_req_val        = (|src_rd_req_val) & ~full;
        src_rd_req_rdy        = '0;
        src_rd_req_rdy[grant] = dst_rd_req_rdy & ~full;
    end

    assign head = tag_mem[rd_ptr];

    always_comb begin
        src_rd_resp_val = '0;
        dst_rd_resp_rdy = 1'b0;
        if (!empty) begin
            src_rd_resp_val[head] = dst_rd_resp_val;
            dst_rd_resp_rdy       = src_rd_resp_rdy[head];
        end
    end

    assign src_rd_resp_data = dst_rd_resp_data;
    assign req_hs           = dst_rd_req_val & dst_rd_req_rdy;
    assign resp_hs          = dst_rd_resp_val & dst_rd_resp_rdy;
    assign outst_cnt        = cnt;

    // NOTE: tag storage has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (req_hs) tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            last_grant <= SRC_W'(NUM_SRCS - 1);
        end else begin
            if (req_hs) begin
                wr_ptr     <= ptr_inc(wr_ptr);
                last_grant <= grant;
            end
            if (resp_hs) rd_ptr <= ptr_inc(rd_ptr);
            case ({req_hs, resp_hs})
                2'b10: begin
                    cnt     <= cnt + 1'b1;
                    full_q  <= (cnt == CNT_W'(MAX_OUTST - 1));
                    empty_q <= 1'b0;
                end
                2'b01: begin
                    cnt     <= cnt - 1'b1;
                    full_q  <= 1'b0;
                    empty_q <= (cnt == CNT_W'(1));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rd_arb_mux.sv
// Directed bench for mem_rd_arb_mux: fixed-priority, round-robin and shallow-FIFO instances
// driven through arbitration, full gating, response routing and reset scenarios.
module tb_mem_rd_arb_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] addrs;
    logic [15:0] resp_data;

    // fixed priority, depth 4
    logic [3:0]  fp_val, fp_req_rdy, fp_resp_val, fp_resp_rdy;
    logic [15:0] fp_resp_data, fp_daddr;
    logic        fp_dval, fp_drdy, fp_dresp_val, fp_dresp_rdy;
    logic [2:0]  fp_cnt;
    // round robin, depth 4
    logic [3:0]  rr_val, rr_req_rdy, rr_resp_val, rr_resp_rdy;
    logic [15:0] rr_resp_data, rr_daddr;
    logic        rr_dval, rr_drdy, rr_dresp_val, rr_dresp_rdy;
    logic [2:0]  rr_cnt;
    // fixed priority, depth 2
    logic [3:0]  m2_val, m2_req_rdy, m2_resp_val, m2_resp_rdy;
    logic [15:0] m2_resp_data, m2_daddr;
    logic        m2_dval, m2_drdy, m2_dresp_val, m2_dresp_rdy;
    logic [1:0]  m2_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_rd_arb_mux #(.NUM_SRCS(4), .ADDR_W(16), .DATA_W(16), .MAX_OUTST(4), .ARB_RR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .src_rd_req_val(fp_val), .src_rd_req_addr(addrs), .src_rd_req_rdy(fp_req_rdy),
        .src_rd_resp_val(fp_resp_val), .src_rd_resp_data(fp_resp_data), .src_rd_resp_rdy(fp_resp_rdy),
        .dst_rd_req_val(fp_dval), .dst_rd_req_addr(fp_daddr), .dst_rd_req_rdy(fp_drdy),
        .dst_rd_resp_val(fp_dresp_val), .dst_rd_resp_data(resp_data), .dst_rd_resp_rdy(fp_dresp_rdy),
        .outst_cnt(fp_cnt)
    );

    mem_rd_arb_mux #(.NUM_SRCS(4), .ADDR_W(16), .DATA_W(16), .MAX_OUTST(4), .ARB_RR(1)) dut_rr (
        .clk(clk), .rst(rst),
        .src_rd_req_val(rr_val), .src_rd_req_addr(addrs), .src_rd_req_rdy(rr_req_rdy),
        .src_rd_resp_val(rr_resp_val), .src_rd_resp_data(rr_resp_data), .src_rd_resp_rdy(rr_resp_rdy),
        .dst_rd_req_val(rr_dval), .dst_rd_req_addr(rr_daddr), .dst_rd_req_rdy(rr_drdy),
        .dst_rd_resp_val(rr_dresp_val), .dst_rd_resp_data(resp_data), .dst_rd_resp_rdy(rr_dresp_rdy),
        .outst_cnt(rr_cnt)
    );

    mem_rd_arb_mux #(.NUM_SRCS(4), .ADDR_W(16), .DATA_W(16), .MAX_OUTST(2), .ARB_RR(0)) dut_m2 (
        .clk(clk), .rst(rst),
        .src_rd_req_val(m2_val), .src_rd_req_addr(addrs), .src_rd_req_rdy(m2_req_rdy),
        .src_rd_resp_val(m2_resp_val), .src_rd_resp_data(m2_resp_data), .src_rd_resp_rdy(m2_resp_rdy),
        .dst_rd_req_val(m2_dval), .dst_rd_req_addr(m2_daddr), .dst_rd_req_rdy(m2_drdy),
        .dst_rd_resp_val(m2_dresp_val), .dst_rd_resp_data(resp_data), .dst_rd_resp_rdy(m2_dresp_rdy),
        .outst_cnt(m2_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fp_val = '0; fp_resp_rdy = '0; fp_drdy = 1'b0; fp_dresp_val = 1'b0;
        rr_val = '0; rr_resp_rdy = '0; rr_drdy = 1'b0; rr_dresp_val = 1'b0;
        m2_val = '0; m2_resp_rdy = '0; m2_drdy = 1'b0; m2_dresp_val = 1'b0;
        resp_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        addrs = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        do_reset();

        // reset state, with a response pending downstream that must be held
        fp_dresp_val = 1'b1; fp_resp_rdy = 4'b1111;
        #2;
        check("rst_cnt", fp_cnt, 0);
        check("rst_dresp_rdy", fp_dresp_rdy, 0);
        check("rst_resp_val", fp_resp_val, 0);
        check("rst_dval", fp_dval, 0);
        check("rst_m2_cnt", m2_cnt, 0);

        // fixed priority: src1 and src3 requesting, responses drain each cycle
        do_reset();
        fp_val = 4'b1010; fp_drdy = 1'b1; fp_dresp_val = 1'b1; fp_resp_rdy = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #2;
            check("fp_req_rdy", fp_req_rdy, 4'b0010);
            check("fp_addr", fp_daddr, 16'h2222);
            if (k > 0) begin
                check("fp_resp_val", fp_resp_val, 4'b0010);
                check("fp_cnt", fp_cnt, 1);
            end
            tick();
        end

        // round robin: 0,1,2,3,0 then grant holds while downstream stalls
        do_reset();
        rr_val = 4'b1111; rr_drdy = 1'b1; rr_dresp_val = 1'b1; rr_resp_rdy = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #2;
            check("rr_seq_rdy", rr_req_rdy, 4'b0001 << (k % 4));
            check("rr_seq_addr", rr_daddr, 16'h1111 * ((k % 4) + 1));
            tick();
        end
        rr_drdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("rr_stall_rdy", rr_req_rdy, 4'b0000);
            check("rr_stall_addr", rr_daddr, 16'h2222);
            check("rr_stall_val", rr_dval, 1);
            tick();
        end
        rr_drdy = 1'b1;
        #2;
        check("rr_resume_rdy", rr_req_rdy, 4'b0010);

        // depth-2 FIFO: third request waits for a pop, and not in the pop cycle
        do_reset();
        m2_val = 4'b0111; m2_drdy = 1'b1;
        #2; check("m2_g0", m2_req_rdy, 4'b0001);
        tick(); m2_val = 4'b0110;
        #2; check("m2_g1", m2_req_rdy, 4'b0010); check("m2_cnt1", m2_cnt, 1);
        tick(); m2_val = 4'b0100;
        #2; check("m2_full_val", m2_dval, 0); check("m2_full_rdy", m2_req_rdy, 0); check("m2_cnt2", m2_cnt, 2);
        tick(); m2_dresp_val = 1'b1; m2_resp_rdy = 4'b1111;
        #2; check("m2_resp_val", m2_resp_val, 4'b0001); check("m2_dresp_rdy", m2_dresp_rdy, 1);
        check("m2_pop_cycle_val", m2_dval, 0);
        tick(); m2_dresp_val = 1'b0;
        #2; check("m2_after_pop_cnt", m2_cnt, 1); check("m2_third_val", m2_dval, 1);
        check("m2_third_addr", m2_daddr, 16'h3333); check("m2_third_rdy", m2_req_rdy, 4'b0100);
        tick(); m2_val = '0;
        #2; check("m2_cnt_final", m2_cnt, 2);

        // response routing: src2 then src0, with src2 back-pressuring first
        do_reset();
        fp_drdy = 1'b1; fp_val = 4'b0100;
        tick(); fp_val = 4'b0001;
        tick(); fp_val = '0; resp_data = 16'h000A; fp_dresp_val = 1'b1; fp_resp_rdy = 4'b1011;
        #2; check("rt_val_a", fp_resp_val, 4'b0100); check("rt_hold0", fp_dresp_rdy, 0);
        check("rt_data_a", fp_resp_data, 16'h000A); check("rt_cnt", fp_cnt, 2);
        tick();
        #2; check("rt_hold1", fp_dresp_rdy, 0);
        tick(); fp_resp_rdy = 4'b1111;
        #2; check("rt_release", fp_dresp_rdy, 1); check("rt_val_a2", fp_resp_val, 4'b0100);
        tick(); resp_data = 16'h000B;
        #2; check("rt_val_b", fp_resp_val, 4'b0001); check("rt_data_b", fp_resp_data, 16'h000B);
        check("rt_rdy_b", fp_dresp_rdy, 1);
        tick();
        #2; check("rt_empty_val", fp_resp_val, 0); check("rt_empty_rdy", fp_dresp_rdy, 0);
        check("rt_empty_cnt", fp_cnt, 0);

        // simultaneous push and pop at one outstanding
        do_reset();
        fp_drdy = 1'b1; fp_val = 4'b0001;
        tick(); fp_val = 4'b0010; fp_dresp_val = 1'b1; fp_resp_rdy = 4'b1111;
        #2; check("pp_cnt_before", fp_cnt, 1); check("pp_resp_val", fp_resp_val, 4'b0001);
        check("pp_req_rdy", fp_req_rdy, 4'b0010);
        tick(); fp_val = '0; fp_resp_rdy = 4'b0000;
        #2; check("pp_cnt_after", fp_cnt, 1); check("pp_head", fp_resp_val, 4'b0010);

        // reset with three reads in flight
        do_reset();
        rr_val = 4'b1111; rr_drdy = 1'b1;
        tick(); tick(); tick();
        rr_val = '0;
        #2; check("rf_cnt3", rr_cnt, 3);
        rst = 1'b1; rr_val = 4'b1111; rr_dresp_val = 1'b1; rr_resp_rdy = 4'b1111;
        #2; check("rf_during_rdy", rr_dresp_rdy, 0);
        tick(); rst = 1'b0;
        #2; check("rf_cnt0", rr_cnt, 0); check("rf_dresp_rdy", rr_dresp_rdy, 0);
        check("rf_grant0", rr_req_rdy, 4'b0001); check("rf_addr0", rr_daddr, 16'h1111);
        clear_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
